// File: rtl/mem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM state and read-owner tag.
package mem_arb_pkg;

    typedef enum logic {
        ARB        = 1'b0,
        HOST_BURST = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

endpackage

// File: rtl/starve_counter.sv
// Saturating up-counter: clr has priority over inc, holds at MAX and flags sat.
module starve_counter #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic         sat_o,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MAX_V);
    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port data memory arbiter between the core load/store path and a host loader.
// Issue path is fully combinational; reads are tagged so rdata returns to its originator.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4,
    localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_stall,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dbg_state,
    output logic [CNT_W-1:0]  dbg_starve_cnt
);

    arb_state_t state_q, state_d;
    owner_t     rd_tag_q;
    logic       rd_pend_q;

    logic       in_burst;
    logic       core_wins;
    logic       host_wins;
    logic       access;
    logic       win_we;
    owner_t     win_owner;
    logic       starve_sat;
    logic       starve_inc;
    logic       starve_clr;
    logic [CNT_W-1:0] starve_cnt;

    // The cycle host_lock drops is arbitrated as ARB even though state_q is still HOST_BURST.
    assign in_burst = (state_q == HOST_BURST) && host_lock;

    // All issue-path terms are qualified by reset so nothing is strobed while reset is low.
    always_comb begin
        core_wins  = reset && !in_burst && core_req && !starve_sat;
        host_wins  = reset && host_req && !core_wins;
        access     = core_wins || host_wins;
        win_owner  = host_wins ? OWN_HOST : OWN_CORE;
        win_we     = host_wins ? host_we : core_we;
        mem_addr   = host_wins ? host_addr : core_addr;
        mem_wdata  = host_wins ? host_wdata : core_wdata;
        mem_we     = access && win_we;
        mem_re     = access && !win_we;
        host_gnt   = host_wins;
        core_stall = reset && core_req && !core_wins;
    end

    assign starve_inc = host_req && !host_wins;
    assign starve_clr = host_wins || !host_req || in_burst;

    starve_counter #(
        .MAX (STARVE_MAX),
        .W   (CNT_W)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc_i (starve_inc),
        .clr_i (starve_clr),
        .sat_o (starve_sat),
        .cnt_o (starve_cnt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (host_wins && host_lock) begin
                    state_d = HOST_BURST;
                end
            end
            HOST_BURST: begin
                if (!host_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Asynchronous clear of rd_pend drops any read that was in flight at reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_pend_q <= 1'b0;
            rd_tag_q  <= OWN_CORE;
        end else begin
            rd_pend_q <= mem_re;
            if (mem_re) begin
                rd_tag_q <= win_owner;
            end
        end
    end

    assign core_rdata     = mem_rdata;
    assign host_rdata     = mem_rdata;
    assign core_rvalid    = rd_pend_q && (rd_tag_q == OWN_CORE);
    assign host_rvalid    = rd_pend_q && (rd_tag_q == OWN_HOST);
    assign dbg_state      = state_q;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table vectors, directed corner sequences and a randomized run
// checked against a cycle-level reference model with its own memory image.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int SM = 4;
    localparam int CW = $clog2(SM + 1);

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          core_stall, core_rvalid, host_gnt, host_rvalid;
    logic [DW-1:0] core_rdata, host_rdata;
    logic          mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          dbg_state;
    logic [CW-1:0] dbg_starve_cnt;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_lock(host_lock), .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // Environment memory: synchronous write, registered read data.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          tag;   // 0 = core, 1 = host
        logic [DW-1:0] data;
    } rd_t;
    rd_t           exp_q[$];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] pre [16];
    bit            m_burst = 1'b0;
    int            m_starve = 0;
    // predictions for the current cycle, reused at the clock edge
    logic e_inb, e_cw, e_hw, e_stall, e_acc, e_we;
    logic prev_core_stall = 1'b0, prev_host_wait = 1'b0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0b exp=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_burst  = 1'b0;
        m_starve = 0;
        exp_q.delete();
    endtask

    // Compare all DUT outputs against the model for the current cycle.
    task automatic check_now();
        if (!reset) begin
            chk1("rst_stall", core_stall, 1'b0);
            chk1("rst_gnt", host_gnt, 1'b0);
            chk1("rst_we", mem_we, 1'b0);
            chk1("rst_re", mem_re, 1'b0);
            chk1("rst_crv", core_rvalid, 1'b0);
            chk1("rst_hrv", host_rvalid, 1'b0);
            chk1("rst_state", dbg_state, 1'b0);
            chk8("rst_starve", 8'(dbg_starve_cnt), 8'd0);
            return;
        end
        e_inb   = m_burst && host_lock;
        e_cw    = !e_inb && core_req && (m_starve < SM);
        e_hw    = host_req && !e_cw;
        e_stall = core_req && !e_cw;
        e_acc   = e_cw || e_hw;
        e_we    = e_cw ? core_we : host_we;
        chk1("stall", core_stall, e_stall);
        chk1("gnt", host_gnt, e_hw);
        chk1("mem_we", mem_we, e_acc && e_we);
        chk1("mem_re", mem_re, e_acc && !e_we);
        if (e_acc) chk8("mem_addr", mem_addr, e_cw ? core_addr : host_addr);
        if (e_acc && e_we) chk8("mem_wdata", mem_wdata, e_cw ? core_wdata : host_wdata);
        if (exp_q.size() > 0) begin
            chk1("core_rvalid", core_rvalid, !exp_q[0].tag);
            chk1("host_rvalid", host_rvalid, exp_q[0].tag);
            chk8("rdata", exp_q[0].tag ? host_rdata : core_rdata, exp_q[0].data);
        end else begin
            chk1("core_rvalid_idle", core_rvalid, 1'b0);
            chk1("host_rvalid_idle", host_rvalid, 1'b0);
        end
        chk1("state", dbg_state, m_burst);
        chk8("starve", 8'(dbg_starve_cnt), 8'(m_starve));
    endtask

    // Advance one rising edge and update the model from this cycle's predictions.
    task automatic clock_edge();
        logic [AW-1:0] a;
        @(posedge clk);
        if (reset) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            a = e_cw ? core_addr : host_addr;
            if (e_acc && e_we) ref_mem[a] = e_cw ? core_wdata : host_wdata;
            if (e_acc && !e_we) exp_q.push_back({e_hw, ref_mem[a]});
            if (e_inb || e_hw || !host_req) m_starve = 0;
            else if (m_starve < SM) m_starve = m_starve + 1;
            m_burst = e_inb || (e_hw && host_lock);
            prev_core_stall = e_stall;
            prev_host_wait  = host_req && !e_hw;
        end else begin
            model_reset();
            prev_core_stall = 1'b0;
            prev_host_wait  = 1'b0;
        end
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_now();
        clock_edge();
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        core_req = 1'b0; core_we = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0;
    endtask

    task automatic set_core(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req = req; core_we = we; core_addr = a; core_wdata = d;
    endtask

    task automatic set_host(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic lk);
        host_req = req; host_we = we; host_addr = a; host_wdata = d; host_lock = lk;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          cr, cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        logic          hr, hw;
        logic [AW-1:0] ha;
        logic [DW-1:0] hd;
        logic          e_stall, e_gnt, e_we, e_re;
        logic [AW-1:0] e_addr;
    } vec_t;
    vec_t vt [9];

    initial begin
        // core only read / host only write / both (core wins, host held) / host after
        vt[0] = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h05};
        vt[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h07, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 8'h07};
        vt[2] = '{1'b1, 1'b1, 8'h08, 8'h22, 1'b1, 1'b0, 8'h09, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h08};
        vt[3] = '{1'b1, 1'b0, 8'h0A, 8'h00, 1'b1, 1'b0, 8'h09, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A};
        vt[4] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h09, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h09};
        vt[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vt[6] = '{1'b1, 1'b1, 8'h0B, 8'h33, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h0B};
        vt[7] = '{1'b1, 1'b0, 8'h0D, 8'h00, 1'b1, 1'b0, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0D};
        vt[8] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h0C, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h0C};

        // reset held for a few cycles with requests present
        set_core(1'b1, 1'b0, 8'h01, 8'h00);
        set_host(1'b1, 1'b1, 8'h02, 8'h00, 1'b1);
        repeat (3) cycle();
        idle();
        reset = 1'b1;

        // preload 0x00..0x0F and 0x10 through the host port
        for (int a = 0; a < 16; a++) begin
            pre[a] = 8'($urandom_range(0, 255));
            set_host(1'b1, 1'b1, 8'(a), pre[a], 1'b0);
            cycle();
        end
        set_host(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0);
        cycle();
        idle();
        cycle();

        // table vectors
        for (int i = 0; i < 9; i++) begin
            set_core(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd);
            set_host(vt[i].hr, vt[i].hw, vt[i].ha, vt[i].hd, 1'b0);
            @(negedge clk);
            chk1($sformatf("vec%0d_stall", i), core_stall, vt[i].e_stall);
            chk1($sformatf("vec%0d_gnt", i), host_gnt, vt[i].e_gnt);
            chk1($sformatf("vec%0d_we", i), mem_we, vt[i].e_we);
            chk1($sformatf("vec%0d_re", i), mem_re, vt[i].e_re);
            if (vt[i].e_we || vt[i].e_re) chk8($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
            check_now();
            clock_edge();
        end
        idle();
        cycle();

        // core read of 0x10 holding 0x5A
        set_core(1'b1, 1'b0, 8'h10, 8'h00);
        @(negedge clk);
        chk1("c10_re", mem_re, 1'b1);
        check_now();
        clock_edge();
        idle();
        @(negedge clk);
        chk1("c10_rvalid", core_rvalid, 1'b1);
        chk8("c10_rdata", core_rdata, 8'h5A);
        chk1("c10_host_rvalid", host_rvalid, 1'b0);
        check_now();
        clock_edge();

        // starvation: both requesting, host granted on the 5th cycle
        set_core(1'b1, 1'b0, 8'h03, 8'h00);
        set_host(1'b1, 1'b0, 8'h04, 8'h00, 1'b0);
        for (int i = 1; i <= SM + 1; i++) begin
            @(negedge clk);
            chk1($sformatf("starve_gnt%0d", i), host_gnt, i == SM + 1);
            chk1($sformatf("starve_stall%0d", i), core_stall, i == SM + 1);
            check_now();
            clock_edge();
        end
        idle();
        @(negedge clk);
        chk8("starve_clear", 8'(dbg_starve_cnt), 8'd0);
        check_now();
        clock_edge();

        // host burst: enter alone, then core stalled for 3 locked cycles
        set_host(1'b1, 1'b1, 8'h20, 8'hC3, 1'b1);
        cycle();
        set_core(1'b1, 1'b0, 8'h05, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1($sformatf("burst_stall%0d", i), core_stall, 1'b1);
            chk1($sformatf("burst_gnt%0d", i), host_gnt, 1'b1);
            chk1($sformatf("burst_state%0d", i), dbg_state, 1'b1);
            check_now();
            clock_edge();
        end
        set_host(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        chk1("unlock_stall", core_stall, 1'b0);
        chk1("unlock_re", mem_re, 1'b1);
        check_now();
        clock_edge();
        idle();
        set_host(1'b1, 1'b0, 8'h20, 8'h00, 1'b0);
        cycle();
        idle();
        @(negedge clk);
        chk1("rb20_rvalid", host_rvalid, 1'b1);
        chk8("rb20_rdata", host_rdata, 8'hC3);
        check_now();
        clock_edge();

        // alternating owners, back-to-back reads
        set_core(1'b1, 1'b0, 8'h01, 8'h00);
        cycle();
        idle();
        set_host(1'b1, 1'b0, 8'h02, 8'h00, 1'b0);
        @(negedge clk);
        chk1("alt1_crv", core_rvalid, 1'b1);
        chk8("alt1_data", core_rdata, pre[1]);
        check_now();
        clock_edge();
        idle();
        set_core(1'b1, 1'b0, 8'h03, 8'h00);
        @(negedge clk);
        chk1("alt2_hrv", host_rvalid, 1'b1);
        chk1("alt2_crv", core_rvalid, 1'b0);
        chk8("alt2_data", host_rdata, pre[2]);
        check_now();
        clock_edge();
        idle();
        @(negedge clk);
        chk1("alt3_crv", core_rvalid, 1'b1);
        chk1("alt3_hrv", host_rvalid, 1'b0);
        chk8("alt3_data", core_rdata, pre[3]);
        check_now();
        clock_edge();

        // reset one cycle after a host read issues: no rvalid follows
        set_host(1'b1, 1'b0, 8'h02, 8'h00, 1'b1);
        cycle();
        reset = 1'b0;
        model_reset();
        set_core(1'b1, 1'b0, 8'h01, 8'h00);
        @(negedge clk);
        chk1("rstrd_hrv", host_rvalid, 1'b0);
        chk1("rstrd_gnt", host_gnt, 1'b0);
        chk1("rstrd_stall", core_stall, 1'b0);
        chk1("rstrd_state", dbg_state, 1'b0);
        check_now();
        clock_edge();
        idle();
        reset = 1'b1;
        cycle();

        // idle for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("idle_we", mem_we, 1'b0);
            chk1("idle_re", mem_re, 1'b0);
            chk1("idle_stall", core_stall, 1'b0);
            chk1("idle_gnt", host_gnt, 1'b0);
            check_now();
            clock_edge();
        end

        // randomized traffic honouring the requester hold rule
        for (int i = 0; i < 500; i++) begin
            if (!prev_core_stall)
                set_core($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                         8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
            if (!prev_host_wait) begin
                host_req   = $urandom_range(0, 9) < 5;
                host_we    = $urandom_range(0, 1) == 1;
                host_addr  = 8'($urandom_range(0, 15));
                host_wdata = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 4) == 0) host_lock = ~host_lock;
            cycle();
        end
        idle();
        cycle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Arbitrates the single-port data memory between the processor core and an external host loader (program/data preload, result readback).
- Issues at most one memory access per cycle and tags each read so the returned data reaches its originator.
- Stalls the core's program counter when the core loses arbitration.
- Sits between the core's load/store path and the `memory` instance, driving its `memWrite`/`memRead`/address/data lines.

## Interface
Parameters:
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- STARVE_MAX, 4, maximum consecutive cycles the host may be refused before it preempts the core (≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- core_req  in  1  core requests an access this cycle
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core write data
- core_stall  out  1  core lost arbitration; hold PC and request
- core_rdata  out  DATA_W  read data returned to core
- core_rvalid  out  1  core_rdata valid this cycle
- host_req  in  1  host requests an access
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_lock  in  1  host requests exclusive burst ownership
- host_gnt  out  1  host access issued this cycle
- host_rdata  out  DATA_W  read data returned to host
- host_rvalid  out  1  host_rdata valid this cycle
- mem_we  out  1  memory write strobe
- mem_re  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re

## Operation
- FSM states:
  - ARB: normal per-cycle arbitration.
  - HOST_BURST: host owns the memory exclusively.
- ARB priority:
  - Core wins if core_req and starve_cnt < STARVE_MAX.
  - Otherwise host wins if host_req.
  - No request: mem_we = mem_re = 0.
- Issuing an access: the winner's address and data drive mem_addr and mem_wdata. mem_we = winner_we; mem_re = ~winner_we.
- Grants and stalls (combinational, same cycle):
  - host_gnt = 1 when the host wins.
  - core_stall = core_req & ~core_wins.
- Requester hold rule: a refused requester keeps req, we, addr and wdata stable until it is served.
- starve_cnt:
  - Increments on host_req & ~host_gnt.
  - Saturates at STARVE_MAX.
  - Clears to 0 on host_gnt or ~host_req.
  - Width is $clog2(STARVE_MAX+1).
- Entering HOST_BURST: ARB → HOST_BURST when host_gnt & host_lock.
- In HOST_BURST:
  - The host wins on every host_req.
  - core_stall = core_req.
  - starve_cnt is held at 0.
- Leaving HOST_BURST: HOST_BURST → ARB on the first cycle where host_lock = 0. That cycle is already arbitrated as ARB.
- Read tagging:
  - rd_tag (0 = core, 1 = host) and rd_pend are registered when mem_re is issued.
  - Next cycle, mem_rdata is forwarded combinationally to both rdata outputs.
  - Only the tagged requester's rvalid is driven to 1, gated by rd_pend.
- Writes: no rvalid is generated.
- Back-to-back reads from alternating owners are legal; each rvalid follows its own issue cycle.
- Reset asserted (asynchronous):
  - State becomes ARB; starve_cnt = 0; rd_pend = 0.
  - core_rvalid = host_rvalid = 0.
  - mem_we = mem_re = 0, host_gnt = 0, core_stall = 0 for as long as reset is low.
  - A read in flight when reset asserts is discarded; no rvalid follows.
- Simultaneous host_lock and core_req on the same cycle: normal ARB priority decides entry into HOST_BURST.

## Timing
- Arbitration decision, grant, stall and memory strobes are combinational from the requests; there are no registered outputs on the issue path.
- Read latency: rvalid and rdata appear exactly 1 cycle after issue.
- Worst-case host wait in ARB: STARVE_MAX cycles, after which the host is granted on the next request cycle regardless of the core.
- Core worst-case wait equals the host burst length plus one cycle.
- Outputs after reset release:
  - All strobes, grants and rvalids are 0 until requests arrive.
  - The first grant can occur in the first clk edge cycle after deassertion.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the `arb_state_t` enum (ARB, HOST_BURST);
  - the `owner_t` enum (OWN_CORE = 0, OWN_HOST = 1).
- One natural sub-module, `starve_counter`: a saturating counter with inc/clr inputs and a `sat` output.
- FSM, issue mux and read-tag registers live in `mem_arbiter`.

## Test plan
- Core only, read addr 0x10 with mem holding 0x5A → mem_re same cycle; core_rvalid=1, core_rdata=0x5A next cycle; host_rvalid stays 0.
- core_req and host_req both held, STARVE_MAX=4 → core served 4 cycles with host_gnt=0; host_gnt=1 and core_stall=1 on the 5th cycle; starve_cnt back to 0.
- Host write 0xC3 to 0x20 with host_lock held 3 cycles while core_req=1 → core_stall=1 for those 3 cycles; core served the cycle after lock drops; readback of 0x20 returns 0xC3.
- Alternating reads (core 0x01, host 0x02, core 0x03) → rvalid pulses tagged to the correct owner in consecutive cycles with the matching data.
- Reset pulled low one cycle after a host read issues → host_rvalid never asserts; state returns to ARB; starve_cnt=0.
- No requests for 10 cycles → mem_we=mem_re=0, core_stall=0, host_gnt=0 throughout.
